commit_ctrl: RTL and testbench

Writeback-stage sequencer for the NPC core. Owns the handshake between the LSU/EXU result path and the commit register. It decides the single cycle in which the commit register captures ALU or memory results. For loads and stores it first waits on the memory response. It also produces the retire pulse for PC update and difftest, a 64-bit retired-instruction counter, and sticky halt and error status.

---
 rtl/commit_ctrl_pkg.sv | 20 ++
 rtl/commit_ctrl_timer.sv | 28 ++
 rtl/commit_ctrl.sv | 134 +++++++++++++
 tb/tb_commit_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/commit_ctrl_pkg.sv
// Shared defines for the writeback commit sequencer: FSM encoding,
// error-cause codes and commit-register data-select constants.
package commit_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_MEM = 3'd1,
        ST_COMMIT   = 3'd2,
        ST_HALT     = 3'd3,
        ST_ERROR    = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_MEM     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    localparam logic SEL_ALU_DATA = 1'b0;
    localparam logic SEL_MEM_DATA = 1'b1;

endpackage

// File: rtl/commit_ctrl_timer.sv
// Wait-for-memory timeout counter: cleared when a memory op is accepted,
// counts while enabled, and flags expiry on its final allowed cycle.
module commit_ctrl_timer #(
    parameter int LIMIT = 1024,
    parameter int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire = enable && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/commit_ctrl.sv
// Writeback-stage sequencer: picks the commit-register capture cycle,
// emits the retire pulse, counts retirements and holds halt/error status.
module commit_ctrl
    import commit_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid_pre_i,
    output logic        ready_pre_o,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic        halt_i,
    input  logic        mem_rvalid_i,
    input  logic        mem_bvalid_i,
    input  logic        mem_err_i,
    output logic        we_o,
    output logic        commit_valid_o,
    output logic [63:0] retired_o,
    output logic        halted_o,
    output logic        error_o,
    output logic [1:0]  err_cause_o
);

    state_t state;
    logic   op_is_load;
    logic   halt_q;
    logic   is_mem;
    logic   resp_match;
    logic   timer_clear;
    logic   timer_en;
    logic   expire;

    assign is_mem = is_load_i || is_store_i;

    commit_ctrl_timer #(
        .LIMIT (TIMEOUT_CYCLES),
        .CNT_W (CNT_W)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_en),
        .expire (expire)
    );

    // Handshake is combinational so an ALU op commits in its accept cycle.
    always_comb begin
        we_o        = 1'b0;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        resp_match  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (valid_pre_i) begin
                    if (is_mem) timer_clear = 1'b1;
                    else        we_o        = 1'b1;
                end
            end
            ST_WAIT_MEM: begin
                timer_en   = 1'b1;
                resp_match = op_is_load ? mem_rvalid_i : mem_bvalid_i;
                if (resp_match && !mem_err_i) we_o = 1'b1;
            end
            default: ;
        endcase
        if (reset) we_o = 1'b0;
    end

    assign ready_pre_o = we_o;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            op_is_load     <= 1'b0;
            halt_q         <= 1'b0;
            commit_valid_o <= 1'b0;
            retired_o      <= '0;
            halted_o       <= 1'b0;
            error_o        <= 1'b0;
            err_cause_o    <= ERR_NONE;
        end else begin
            commit_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (valid_pre_i) begin
                        if (is_mem) begin
                            op_is_load <= is_load_i;
                            state      <= ST_WAIT_MEM;
                        end else begin
                            halt_q         <= halt_i;
                            commit_valid_o <= 1'b1;
                            retired_o      <= retired_o + 64'd1;
                            state          <= ST_COMMIT;
                        end
                    end
                end
                ST_WAIT_MEM: begin
                    // A response in the expiry cycle still takes priority.
                    if (resp_match) begin
                        if (mem_err_i) begin
                            error_o     <= 1'b1;
                            err_cause_o <= ERR_MEM;
                            state       <= ST_ERROR;
                        end else begin
                            halt_q         <= halt_i;
                            commit_valid_o <= 1'b1;
                            retired_o      <= retired_o + 64'd1;
                            state          <= ST_COMMIT;
                        end
                    end else if (expire) begin
                        error_o     <= 1'b1;
                        err_cause_o <= ERR_TIMEOUT;
                        state       <= ST_ERROR;
                    end
                end
                ST_COMMIT: begin
                    if (halt_q) begin
                        halted_o <= 1'b1;
                        state    <= ST_HALT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_HALT:  state <= ST_HALT;
                ST_ERROR: state <= ST_ERROR;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_commit_ctrl.sv
// Directed self-checking bench for commit_ctrl with a short timeout window.
module tb_commit_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid_pre_i, is_load_i, is_store_i, halt_i;
    logic        mem_rvalid_i, mem_bvalid_i, mem_err_i;
    logic        ready_pre_o, we_o, commit_valid_o;
    logic [63:0] retired_o;
    logic        halted_o, error_o;
    logic [1:0]  err_cause_o;

    int tests_run    = 0;
    int tests_failed = 0;

    commit_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .valid_pre_i    (valid_pre_i),
        .ready_pre_o    (ready_pre_o),
        .is_load_i      (is_load_i),
        .is_store_i     (is_store_i),
        .halt_i         (halt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_bvalid_i   (mem_bvalid_i),
        .mem_err_i      (mem_err_i),
        .we_o           (we_o),
        .commit_valid_o (commit_valid_o),
        .retired_o      (retired_o),
        .halted_o       (halted_o),
        .error_o        (error_o),
        .err_cause_o    (err_cause_o)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs;
        valid_pre_i = 0; is_load_i = 0; is_store_i = 0; halt_i = 0;
        mem_rvalid_i = 0; mem_bvalid_i = 0; mem_err_i = 0;
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 1;
        valid_pre_i = 1;
        tick();
        #1;
        tests_run++; if (we_o !== 1'b0 || ready_pre_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_we: we=%b ready=%b expected 0 0", we_o, ready_pre_o); end
        tests_run++; if (retired_o !== 64'd0) begin tests_failed++; $display("[TB] FAIL reset_retired: got %0d expected 0", retired_o); end
        tests_run++; if ({commit_valid_o, halted_o, error_o, err_cause_o} !== 5'b0) begin tests_failed++; $display("[TB] FAIL reset_flags: got cv=%b h=%b e=%b c=%0d expected all 0", commit_valid_o, halted_o, error_o, err_cause_o); end
        clear_inputs();
        tick();
        reset = 0;
        tick();
    endtask

    task automatic test_alu;
        valid_pre_i = 1;
        #1;
        tests_run++; if (we_o !== 1'b1 || ready_pre_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL alu_accept: we=%b ready=%b expected 1 1", we_o, ready_pre_o); end
        tick();
        valid_pre_i = 0;
        tests_run++; if (commit_valid_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL alu_commit: got %b expected 1", commit_valid_o); end
        tick();
        tests_run++; if (commit_valid_o !== 1'b0 || retired_o !== 64'd1) begin tests_failed++; $display("[TB] FAIL alu_retired: cv=%b retired=%0d expected 0 1", commit_valid_o, retired_o); end
    endtask

    task automatic test_load;
        int bad_ready = 0;
        valid_pre_i = 1; is_load_i = 1;
        #1;
        if (ready_pre_o !== 1'b0 || we_o !== 1'b0) bad_ready++;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (ready_pre_o !== 1'b0 || we_o !== 1'b0 || commit_valid_o !== 1'b0) bad_ready++;
            tick();
        end
        tests_run++; if (bad_ready !== 0) begin tests_failed++; $display("[TB] FAIL load_wait: %0d cycles with handshake high, expected 0", bad_ready); end
        mem_rvalid_i = 1;
        #1;
        tests_run++; if (we_o !== 1'b1 || ready_pre_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL load_rvalid: we=%b ready=%b expected 1 1", we_o, ready_pre_o); end
        tick();
        clear_inputs();
        tests_run++; if (commit_valid_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL load_commit: got %b expected 1", commit_valid_o); end
        tick();
        tests_run++; if (retired_o !== 64'd2) begin tests_failed++; $display("[TB] FAIL load_retired: got %0d expected 2", retired_o); end
    endtask

    task automatic test_store_stray;
        valid_pre_i = 1; is_store_i = 1;
        tick();
        mem_rvalid_i = 1;
        #1;
        tests_run++; if (we_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL store_stray_rvalid: we=%b expected 0", we_o); end
        tick();
        mem_rvalid_i = 0;
        tests_run++; if (commit_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL store_no_commit: cv=%b expected 0", commit_valid_o); end
        tick();
        mem_bvalid_i = 1;
        #1;
        tests_run++; if (we_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL store_bvalid: we=%b expected 1", we_o); end
        tick();
        clear_inputs();
        tests_run++; if (commit_valid_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL store_commit: got %b expected 1", commit_valid_o); end
        tick();
        tests_run++; if (retired_o !== 64'd3) begin tests_failed++; $display("[TB] FAIL store_retired: got %0d expected 3", retired_o); end
    endtask

    task automatic test_back_to_back;
        mem_rvalid_i = 1; mem_bvalid_i = 1;
        #1;
        tests_run++; if (we_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL stale_idle: we=%b expected 0", we_o); end
        tick();
        mem_rvalid_i = 0; mem_bvalid_i = 0;
        valid_pre_i = 1;
        #1;
        tests_run++; if (we_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_first: we=%b expected 1", we_o); end
        tick();
        tests_run++; if (commit_valid_o !== 1'b1 || we_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_commit_gap: cv=%b we=%b expected 1 0", commit_valid_o, we_o); end
        tick();
        tests_run++; if (we_o !== 1'b1 || commit_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_second: we=%b cv=%b expected 1 0", we_o, commit_valid_o); end
        tick();
        valid_pre_i = 0;
        tick();
        tests_run++; if (retired_o !== 64'd5) begin tests_failed++; $display("[TB] FAIL b2b_retired: got %0d expected 5", retired_o); end
    endtask

    task automatic test_mem_err;
        valid_pre_i = 1; is_load_i = 1; is_store_i = 1;
        tick();
        mem_bvalid_i = 1; mem_err_i = 1;
        #1;
        tests_run++; if (we_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL both_flags_as_load: we=%b expected 0 on bvalid", we_o); end
        tick();
        mem_bvalid_i = 0; mem_rvalid_i = 1;
        #1;
        tests_run++; if (we_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL err_no_we: we=%b expected 0", we_o); end
        tick();
        clear_inputs();
        tests_run++; if (error_o !== 1'b1 || err_cause_o !== 2'd1) begin tests_failed++; $display("[TB] FAIL err_cause_mem: e=%b cause=%0d expected 1 1", error_o, err_cause_o); end
        tests_run++; if (retired_o !== 64'd5 || commit_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL err_retired: retired=%0d cv=%b expected 5 0", retired_o, commit_valid_o); end
        valid_pre_i = 1;
        #1;
        tests_run++; if (we_o !== 1'b0 || ready_pre_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL err_stuck: we=%b ready=%b expected 0 0", we_o, ready_pre_o); end
        clear_inputs();
        reset = 1;
        #1;
        tests_run++; if (error_o !== 1'b0 || err_cause_o !== 2'd0 || retired_o !== 64'd0) begin tests_failed++; $display("[TB] FAIL err_async_reset: e=%b cause=%0d retired=%0d expected 0 0 0", error_o, err_cause_o, retired_o); end
        tick();
        reset = 0;
        tick();
    endtask

    task automatic test_timeout;
        int early = 0;
        valid_pre_i = 1; is_load_i = 1;
        tick();
        for (int i = 1; i <= 8; i++) begin
            if (error_o !== 1'b0 || we_o !== 1'b0) early++;
            tick();
        end
        tests_run++; if (early !== 0) begin tests_failed++; $display("[TB] FAIL timeout_early: %0d bad wait cycles, expected 0", early); end
        tests_run++; if (error_o !== 1'b1 || err_cause_o !== 2'd2) begin tests_failed++; $display("[TB] FAIL timeout_cause: e=%b cause=%0d expected 1 2", error_o, err_cause_o); end
        mem_rvalid_i = 1; is_load_i = 0;
        #1;
        tests_run++; if (we_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL timeout_stuck: we=%b expected 0", we_o); end
        tick();
        tick();
        tests_run++; if (error_o !== 1'b1 || err_cause_o !== 2'd2 || retired_o !== 64'd0 || commit_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL timeout_hold: e=%b cause=%0d retired=%0d cv=%b expected 1 2 0 0", error_o, err_cause_o, retired_o, commit_valid_o); end
        clear_inputs();
        reset = 1;
        tick();
        reset = 0;
        tick();
    endtask

    task automatic test_halt_reset;
        valid_pre_i = 1; halt_i = 1;
        #1;
        tests_run++; if (we_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL halt_accept: we=%b expected 1", we_o); end
        tick();
        halt_i = 0; valid_pre_i = 0;
        tick();
        tests_run++; if (halted_o !== 1'b1 || retired_o !== 64'd1) begin tests_failed++; $display("[TB] FAIL halt_set: h=%b retired=%0d expected 1 1", halted_o, retired_o); end
        valid_pre_i = 1;
        #1;
        tests_run++; if (we_o !== 1'b0 || ready_pre_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL halt_blocks: we=%b ready=%b expected 0 0", we_o, ready_pre_o); end
        tick();
        tests_run++; if (commit_valid_o !== 1'b0 || retired_o !== 64'd1) begin tests_failed++; $display("[TB] FAIL halt_no_retire: cv=%b retired=%0d expected 0 1", commit_valid_o, retired_o); end
        clear_inputs();
        reset = 1;
        #1;
        tests_run++; if (halted_o !== 1'b0 || retired_o !== 64'd0) begin tests_failed++; $display("[TB] FAIL halt_async_reset: h=%b retired=%0d expected 0 0", halted_o, retired_o); end
        tick();
        reset = 0;
        tick();
        valid_pre_i = 1; is_load_i = 1;
        tick();
        tick();
        reset = 1;
        #1;
        reset = 0;
        clear_inputs();
        mem_rvalid_i = 1;
        #1;
        tests_run++; if (we_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_drops_wait: we=%b expected 0", we_o); end
        tick();
        mem_rvalid_i = 0;
        tick();
        tests_run++; if (commit_valid_o !== 1'b0 || retired_o !== 64'd0 || error_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_no_commit: cv=%b retired=%0d e=%b expected 0 0 0", commit_valid_o, retired_o, error_o); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store_stray();
        test_back_to_back();
        test_mem_err();
        test_timeout();
        test_halt_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
